serial_word_receiver: RTL
=========================

// Module: serial_word_receiver
// PURPOSE
//  Serial-to-parallel receive end for the team's shift-register serial links.
//  Collects a framed bit stream MSB- or LSB-first into a WIDTH-bit word.
//  Presents the word on a valid/ready output handshake.
//  Sits between a serial pin/shift-out source and a parallel consumer.
// PARAMETERS
//  WIDTH  4  data bits per frame (>=2)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      async reset, active-low
//  start       in   1      begin a frame (sampled in IDLE/DONE)
//  lsb_first   in   1      1: first bit -> dout[0]; 0: first bit -> dout[WIDTH-1]; latched on start
//  sin         in   1      serial data bit
//  sin_valid   in   1      sin is a valid bit this cycle
//  dout        out  WIDTH  received word, stable while dout_valid
//  dout_valid  out  1      word available
//  dout_ready  in   1      consumer accepts word
//  busy        out  1      frame in progress (state SHIFT)
//  overrun     out  1      sticky: start arrived while an unconsumed word was held
//  parity_err  out  1      parity result, qualified by dout_valid
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0, bit count=0.
//  Reset mid-frame aborts the frame; partial bits are discarded.
//  FSM states IDLE, SHIFT, DONE (all transitions on posedge clk):
//   IDLE : start=1 -> SHIFT, latch lsb_first, count=0; sin/sin_valid ignored.
//   SHIFT: each cycle with sin_valid=1 accepts one bit; sin_valid=0 holds (gaps allowed).
//          lsb_first=1: shift right, new bit into MSB; lsb_first=0: shift left, new bit into LSB.
//          start is ignored in SHIFT (no restart).
//          Last bit accepted -> DONE; dout and dout_valid update on that same edge
//          (dout_valid=1 on the cycle after the last bit is presented).
//   DONE : dout_valid=1, dout held. dout_ready=1 -> IDLE, dout_valid=0 next cycle.
//          start=1 with dout_ready=1 -> SHIFT directly; no overrun; relatch lsb_first.
//          start=1 with dout_ready=0 -> overrun<=1 and start is dropped; state and dout unchanged.
//  Shift register and count are internal; dout updates only on frame completion.
//  Count width = $clog2(WIDTH+1).
//  overrun clears only on reset.
//  busy = (state==SHIFT).
// CONFIGURATION
//  PARITY_CHK_EN defined:
//   - Frame carries WIDTH data bits plus 1 trailing even-parity bit, accepted under sin_valid like data.
//   - Parity bit is not shifted into dout.
//   - parity_err = ^{data,parity_bit} is registered with dout_valid and held through DONE.
//  PARITY_CHK_EN undefined:
//   - Frame is WIDTH bits.
//   - parity_err tied 0; port is always present.
// STRUCTURE
//  Package serial_rx_pkg:
//   - typedef enum {IDLE,SHIFT,DONE} rx_state_t
//   - localparam DEFAULT_WIDTH=4
//   - shift-direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1
//  Sub-module rx_shift_core:
//   - bidirectional WIDTH-bit shift register with shift enable, direction, serial in and clear.
//   - Top level holds the FSM, bit counter, handshake, overrun and parity logic.
// TESTING (WIDTH=4)
//  1. rst=0 at t=0, then release -> all outputs 0, busy=0; asserting rst again mid-test -> immediate clear.
//  2. start, lsb_first=0, bits 1,0,1,1 on consecutive cycles -> dout=4'b1011;
//     dout_valid=1 one cycle after 4th bit; held until dout_ready=1.
//  3. start, lsb_first=1, bits 1,0,1,1 -> dout=4'b1101, dout_valid=1, parity_err=0 (macro off).
//  4. bits 0,1,1,0 with sin_valid=0 gaps of 1-3 cycles -> dout=4'b0110; busy=1 throughout SHIFT.
//  5. Word held, dout_ready=0, pulse start -> overrun=1, dout unchanged.
//     Then start+dout_ready same cycle -> busy=1 next cycle, no extra overrun.
//  6. Reset after 2 of 4 bits, then full frame 1,1,0,0 MSB-first -> dout=4'b1100, overrun=0.
//     With PARITY_CHK_EN: bits 1,0,1,1 + parity 0 -> parity_err=1; + parity 1 -> parity_err=0.

Source files
------------

// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// serial_rx_pkg : shared types and constants for the serial word receiver
// Revision 1.0
// ============================================================================
package serial_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } rx_state_t;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rx_shift_core.sv
`default_nettype none
// ============================================================================
// rx_shift_core : bidirectional WIDTH-bit shift register with clear
// Revision 1.0
// ============================================================================
module rx_shift_core
   import serial_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] next_word
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // next_word is exposed so the parent can capture the completed word on the
   // same edge the final bit is shifted in.
   always_comb begin
      next_word = (dir == DIR_LSB_FIRST) ? {sin, sr_q[WIDTH-1:1]}
                                         : {sr_q[WIDTH-2:0], sin};
      sr_d = sr_q;
      if (clr) begin
         sr_d = '0;
      end else if (shift_en) begin
         sr_d = next_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign word = sr_q;

endmodule
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// serial_word_receiver : framed serial-to-parallel receiver, valid/ready out
// Option macro PARITY_CHK_EN adds a trailing even-parity bit per frame.
// Revision 1.0
// ============================================================================
module serial_word_receiver
   import serial_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             lsb_first,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

`ifdef PARITY_CHK_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;
`ifdef PARITY_CHK_EN
   logic             parity_err_q, parity_err_d;
`endif

   logic             sr_clr;
   logic             sr_shift_en;
   logic [WIDTH-1:0] sr_word;
   logic [WIDTH-1:0] sr_next;

   rx_shift_core #(.WIDTH(WIDTH)) u_shift_core (
      .clk       (clk),
      .rst       (rst),
      .clr       (sr_clr),
      .shift_en  (sr_shift_en),
      .dir       (dir_q),
      .sin       (sin),
      .word      (sr_word),
      .next_word (sr_next)
   );

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      dir_d        = dir_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
`ifdef PARITY_CHK_EN
      parity_err_d = parity_err_q;
`endif
      sr_clr       = 1'b0;
      sr_shift_en  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               dir_d   = lsb_first;
               count_d = '0;
               sr_clr  = 1'b1;
            end
         end

         SHIFT: begin
            if (sin_valid) begin
`ifdef PARITY_CHK_EN
               // The trailing parity bit is counted but never enters the word.
               sr_shift_en = (count_q < CNT_W'(WIDTH));
`else
               sr_shift_en = 1'b1;
`endif
               if (count_q == LAST_IDX) begin
                  state_d      = DONE;
                  count_d      = '0;
                  dout_valid_d = 1'b1;
`ifdef PARITY_CHK_EN
                  dout_d       = sr_word;
                  parity_err_d = ^{sr_word, sin};
`else
                  dout_d       = sr_next;
`endif
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end

         DONE: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
`ifdef PARITY_CHK_EN
               parity_err_d = 1'b0;
`endif
               if (start) begin
                  state_d = SHIFT;
                  dir_d   = lsb_first;
                  count_d = '0;
                  sr_clr  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (start) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         dir_q        <= DIR_MSB_FIRST;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef PARITY_CHK_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         dir_q        <= dir_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
`ifdef PARITY_CHK_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (state_q == SHIFT);
   assign overrun    = overrun_q;
`ifdef PARITY_CHK_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
